// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer
// Description : Programmable down-counting timer. Loads a start value,
//               decrements on every enabled cycle and signals expiry with a
//               one-cycle pulse and a sticky interrupt flag. Supports
//               one-shot and auto-reload modes, and records expiries that
//               occur while the interrupt is still pending.
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             auto_reload,
    input  logic             irq_ack,
    output logic [WIDTH-1:0] count,
    output logic             expired,
    output logic             irq,
    output logic             missed,
    output logic             running
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_expired;
    logic             r_irq;
    logic             r_missed;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             w_expired_nxt;
    logic             w_irq_nxt;
    logic             w_missed_nxt;
    logic             w_expire;

    // Next-state logic: load has top priority, then counting in RUN.
    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_reload_nxt  = r_reload;
        w_expired_nxt = 1'b0;
        w_irq_nxt     = r_irq;
        w_missed_nxt  = r_missed;
        w_expire      = 1'b0;

        if (load) begin
            w_reload_nxt = load_value;
            w_count_nxt  = load_value;
            w_state_nxt  = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (enable) begin
                        if (r_count != '0) begin
                            w_count_nxt = r_count - 1'b1;
                        end else begin
                            w_expire      = 1'b1;
                            w_expired_nxt = 1'b1;
                            if (auto_reload) begin
                                w_count_nxt = r_reload;
                            end else begin
                                w_state_nxt = ST_DONE;
                            end
                        end
                    end
                end
                ST_IDLE, ST_DONE: begin
                    w_state_nxt = r_state;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        // Acknowledge clears both flags; a simultaneous expiry re-sets irq
        // but cannot flag a miss, since the earlier irq was just serviced.
        if (irq_ack) begin
            w_irq_nxt    = 1'b0;
            w_missed_nxt = 1'b0;
        end
        if (w_expire) begin
            w_irq_nxt = 1'b1;
            if (r_irq && !irq_ack) begin
                w_missed_nxt = 1'b1;
            end
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_reload  <= '0;
            r_expired <= 1'b0;
            r_irq     <= 1'b0;
            r_missed  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_reload  <= w_reload_nxt;
            r_expired <= w_expired_nxt;
            r_irq     <= w_irq_nxt;
            r_missed  <= w_missed_nxt;
        end
    end

    assign count   = r_count;
    assign expired = r_expired;
    assign irq     = r_irq;
    assign missed  = r_missed;
    assign running = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_countdown_timer
// Description : Self-checking bench for countdown_timer. Drives a 32-bit and
//               a 4-bit instance from shared controls; uses a vector table,
//               hand-written corner sequences and a randomized run against
//               an abstract reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

    logic        clk;
    logic        rst;
    logic        load;
    logic [31:0] lv32;
    logic [3:0]  lv4;
    logic        enable;
    logic        auto_reload;
    logic        irq_ack;

    logic [31:0] count32;
    logic        exp32, irq32, mis32, run32;
    logic [3:0]  count4;
    logic        exp4, irq4, mis4, run4;

    int n_pass;
    int n_total;

    countdown_timer #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .load(load), .load_value(lv32),
        .enable(enable), .auto_reload(auto_reload), .irq_ack(irq_ack),
        .count(count32), .expired(exp32), .irq(irq32), .missed(mis32),
        .running(run32)
    );

    countdown_timer #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .load(load), .load_value(lv4),
        .enable(enable), .auto_reload(auto_reload), .irq_ack(irq_ack),
        .count(count4), .expired(exp4), .irq(irq4), .missed(mis4),
        .running(run4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector record: inputs applied for one edge, outputs expected after it.
    typedef struct {
        bit          ld;
        logic [31:0] lv;
        bit          en;
        bit          ar;
        bit          ack;
        logic [31:0] e_cnt;
        bit          e_exp;
        bit          e_irq;
        bit          e_mis;
        bit          e_run;
    } vec_t;

    // Abstract model state: mode 0=idle, 1=counting, 2=finished.
    typedef struct {
        logic [63:0] cnt;
        logic [63:0] rel;
        int          mode;
        bit          exp;
        bit          irq;
        bit          mis;
    } mstate_t;

    function automatic vec_t mk(int ld, int lv, int en, int ar, int ack,
                                int c, int e, int i, int m, int r);
        vec_t v;
        v.ld = (ld != 0); v.lv = lv; v.en = (en != 0); v.ar = (ar != 0);
        v.ack = (ack != 0); v.e_cnt = c; v.e_exp = (e != 0);
        v.e_irq = (i != 0); v.e_mis = (m != 0); v.e_run = (r != 0);
        return v;
    endfunction

    function automatic mstate_t mreset();
        mstate_t s;
        s.cnt = 0; s.rel = 0; s.mode = 0; s.exp = 0; s.irq = 0; s.mis = 0;
        return s;
    endfunction

    function automatic mstate_t mstep(mstate_t s, bit ld, logic [63:0] lv,
                                      bit en, bit ar, bit ack,
                                      logic [63:0] mask);
        mstate_t n;
        bit      fire;
        n     = s;
        n.exp = 0;
        fire  = !ld && (s.mode == 1) && en && (s.cnt == 0);
        if (ld) begin
            n.cnt  = lv & mask;
            n.rel  = lv & mask;
            n.mode = 1;
        end else if (s.mode == 1 && en) begin
            if (s.cnt > 0) begin
                n.cnt = s.cnt - 1;
            end else begin
                n.exp = 1;
                if (ar) n.cnt = s.rel;
                else    n.mode = 2;
            end
        end
        if (ack) begin
            n.irq = 0;
            n.mis = 0;
        end
        if (fire) begin
            n.irq = 1;
            if (s.irq && !ack) n.mis = 1;
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] c, input bit e,
                         input bit i, input bit m, input bit r);
        chk({tag, " count"},   64'(count32), 64'(c));
        chk({tag, " expired"}, 64'(exp32),   64'(e));
        chk({tag, " irq"},     64'(irq32),   64'(i));
        chk({tag, " missed"},  64'(mis32),   64'(m));
        chk({tag, " running"}, 64'(run32),   64'(r));
    endtask

    vec_t    tbl[27];
    mstate_t m32;
    mstate_t m4;

    initial begin
        n_pass = 0; n_total = 0;
        rst = 1'b1; load = 1'b0; lv32 = '0; lv4 = '0;
        enable = 1'b0; auto_reload = 1'b0; irq_ack = 1'b0;

        // One-shot N=3, then load collision, auto-reload pause, N=0 reload.
        tbl[0]  = mk(1, 3, 1, 0, 0,  3, 0, 0, 0, 1);
        tbl[1]  = mk(0, 0, 1, 0, 0,  2, 0, 0, 0, 1);
        tbl[2]  = mk(0, 0, 1, 0, 0,  1, 0, 0, 0, 1);
        tbl[3]  = mk(0, 0, 1, 0, 0,  0, 0, 0, 0, 1);
        tbl[4]  = mk(0, 0, 1, 0, 0,  0, 1, 1, 0, 0);
        tbl[5]  = mk(0, 0, 1, 0, 0,  0, 0, 1, 0, 0);
        tbl[6]  = mk(0, 0, 1, 0, 1,  0, 0, 0, 0, 0);
        tbl[7]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 1);
        tbl[8]  = mk(0, 0, 1, 0, 0,  0, 1, 1, 0, 0);
        tbl[9]  = mk(1, 0, 0, 0, 0,  0, 0, 1, 0, 1);
        tbl[10] = mk(1, 7, 1, 0, 0,  7, 0, 1, 0, 1);
        tbl[11] = mk(0, 0, 0, 0, 0,  7, 0, 1, 0, 1);
        tbl[12] = mk(0, 0, 1, 1, 0,  6, 0, 1, 0, 1);
        tbl[13] = mk(1, 2, 1, 1, 1,  2, 0, 0, 0, 1);
        tbl[14] = mk(0, 0, 1, 1, 0,  1, 0, 0, 0, 1);
        tbl[15] = mk(0, 0, 0, 1, 0,  1, 0, 0, 0, 1);
        tbl[16] = mk(0, 0, 0, 1, 0,  1, 0, 0, 0, 1);
        tbl[17] = mk(0, 0, 1, 1, 0,  0, 0, 0, 0, 1);
        tbl[18] = mk(0, 0, 1, 1, 0,  2, 1, 1, 0, 1);
        tbl[19] = mk(0, 0, 1, 1, 0,  1, 0, 1, 0, 1);
        tbl[20] = mk(0, 0, 1, 1, 0,  0, 0, 1, 0, 1);
        tbl[21] = mk(0, 0, 1, 1, 0,  2, 1, 1, 1, 1);
        tbl[22] = mk(1, 0, 1, 1, 1,  0, 0, 0, 0, 1);
        tbl[23] = mk(0, 0, 1, 1, 0,  0, 1, 1, 0, 1);
        tbl[24] = mk(0, 0, 1, 1, 0,  0, 1, 1, 1, 1);
        tbl[25] = mk(0, 0, 1, 1, 1,  0, 1, 1, 0, 1);
        tbl[26] = mk(0, 0, 0, 1, 0,  0, 0, 1, 0, 1);

        // Reset state while rst is held.
        #7;
        chk32("reset", 32'd0, 0, 0, 0, 0);
        #5 rst = 1'b0;

        // Table-driven vectors on the 32-bit instance.
        for (int k = 0; k < 27; k++) begin
            load = tbl[k].ld; lv32 = tbl[k].lv; lv4 = tbl[k].lv[3:0];
            enable = tbl[k].en; auto_reload = tbl[k].ar; irq_ack = tbl[k].ack;
            step();
            chk32($sformatf("vec%0d", k), tbl[k].e_cnt, tbl[k].e_exp,
                  tbl[k].e_irq, tbl[k].e_mis, tbl[k].e_run);
        end

        // Asynchronous reset mid-count, then enable is ignored in IDLE.
        load = 1'b1; lv32 = 32'd5; lv4 = 4'd5; enable = 1'b0; irq_ack = 1'b0;
        step();
        load = 1'b0;
        chk("preload count", 64'(count32), 64'd5);
        #2 rst = 1'b1;
        #1;
        chk32("async rst", 32'd0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0; enable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("idle count", 64'(count32), 64'd0);
            chk("idle expired", 64'(exp32), 64'd0);
        end

        // Width wrap on the 4-bit instance: 15..0 then reload to 15.
        load = 1'b1; lv4 = 4'd15; lv32 = 32'd15; auto_reload = 1'b1;
        enable = 1'b1;
        step();
        load = 1'b0;
        chk("wrap load", 64'(count4), 64'd15);
        for (int p = 0; p < 2; p++) begin
            for (int k = 1; k <= 15; k++) begin
                step();
                chk("wrap count", 64'(count4), 64'(15 - k));
                chk("wrap expired", 64'(exp4), 64'd0);
            end
            step();
            chk("wrap reload", 64'(count4), 64'd15);
            chk("wrap pulse", 64'(exp4), 64'd1);
        end

        // Randomized run against the reference model, both widths.
        @(negedge clk);
        rst = 1'b1; load = 1'b0; enable = 1'b0; irq_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m32 = mreset();
        m4  = mreset();
        for (int k = 0; k < 400; k++) begin
            load        = ($urandom_range(0, 15) == 0);
            lv32        = 32'($urandom_range(0, 6));
            lv4         = 4'($urandom_range(0, 15));
            enable      = ($urandom_range(0, 3) != 0);
            auto_reload = ($urandom_range(0, 2) != 0);
            irq_ack     = ($urandom_range(0, 5) == 0);
            m32 = mstep(m32, load, 64'(lv32), enable, auto_reload, irq_ack,
                        64'hFFFF_FFFF);
            m4  = mstep(m4, load, 64'(lv4), enable, auto_reload, irq_ack,
                        64'hF);
            step();
            chk32("rnd32", m32.cnt[31:0], m32.exp, m32.irq, m32.mis,
                  (m32.mode == 1));
            chk("rnd4 count",   64'(count4), m4.cnt);
            chk("rnd4 expired", 64'(exp4),   64'(m4.exp));
            chk("rnd4 irq",     64'(irq4),   64'(m4.irq));
            chk("rnd4 missed",  64'(mis4),   64'(m4.mis));
            chk("rnd4 running", 64'(run4),   64'(m4.mode == 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/countdown_timer.md
# countdown_timer

Programmable down-counting timer for the multi-cycle CPU's peripheral side, complementing the free-running up-counter that wraps at a limit. It loads a start value, decrements once per enabled cycle, and flags expiry on reaching zero. Expiry produces a one-cycle `expired` pulse and a sticky `irq` that is held until software acknowledges it. One-shot and auto-reload modes are supported, and lost expiries are recorded in a `missed` flag.

## Interface
- `WIDTH`, default 32: counter and load-value width.

- `clk`  in  1  clock; all state changes on posedge.
- `rst`  in  1  reset; asynchronous, active-high.
- `load`  in  1  one-cycle strobe; captures `load_value`.
- `load_value`  in  WIDTH  start/reload value N.
- `enable`  in  1  level; counting advances only while high.
- `auto_reload`  in  1  level; sampled at the expiry edge.
- `irq_ack`  in  1  one-cycle strobe; clears `irq` and `missed`.
- `count`  out  WIDTH  current counter value, registered.
- `expired`  out  1  one-cycle pulse per expiry, registered.
- `irq`  out  1  sticky expiry flag.
- `missed`  out  1  sticky flag: an expiry occurred while `irq` was already set.
- `running`  out  1  high in state RUN.

## Operation
- Internal state: `reload_reg` (WIDTH bits) and a 2-bit FSM with states IDLE, RUN, DONE.
- Reset values: state=IDLE, `count`=0, `reload_reg`=0, `expired`=0, `irq`=0, `missed`=0, `running`=0.
- `load`=1 (any state, highest priority):
  - `reload_reg`<=`load_value`, `count`<=`load_value`, state<=RUN.
  - `expired` is 0 that cycle, even if an expiry would otherwise have occurred.
- IDLE / DONE without `load`: `count` holds; `enable` is ignored.
- RUN with `enable`=0: everything holds.
- RUN with `enable`=1 and `count`!=0: `count`<=`count`-1.
- RUN with `enable`=1 and `count`==0 (expiry):
  - `expired`<=1 for one cycle.
  - `irq`<=1.
  - If `irq` was already 1, `missed`<=1.
  - If `auto_reload`=1: `count`<=`reload_reg`, remain in RUN.
  - If `auto_reload`=0: `count` stays 0, state<=DONE.
- Period: N+1 enabled cycles per expiry. N=0 with auto-reload expires on every enabled cycle.
- Arithmetic is unsigned, modulo 2^WIDTH. Decrement never occurs at 0, so there is no underflow.
- `irq_ack`=1 clears `irq` and `missed`. If `irq_ack` coincides with a new expiry, the set wins:
  - `irq` ends at 1.
  - `missed` ends at 0, because that `irq` was just acknowledged.
- `running`=(state==RUN).

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- `load` at edge k: `count`=N and `running`=1 visible after edge k.
- First decrement happens at the first edge after k with `enable`=1.
- Expiry edge: the edge at which RUN, `enable`=1 and `count`==0 are sampled.
  - After that edge: `expired`=1, `irq`=1, `count`=`reload_reg` or 0.
  - `expired` returns to 0 on the next edge unless another expiry occurs.
- With continuous `enable`: `expired` rises exactly N+1 edges after the load edge.
  - Auto-reload: repeats every N+1 edges.
- Asynchronous `rst` mid-count forces all reset values immediately. The first edge after deassertion behaves as from IDLE.
- `load` during DONE or during RUN restarts counting at N without a glitch on `expired`.

## Test plan
- Reset then idle: assert `rst` mid-run with `count`=5 -> all outputs 0 immediately; `enable`=1 for 10 cycles -> `count` stays 0, no `expired`.
- One-shot: load N=3, `auto_reload`=0, `enable`=1 continuously -> `count` 3,2,1,0; `expired` one cycle at the 4th edge; `irq`=1; `running`=0; `count` holds 0 thereafter.
- Auto-reload with pause: load N=2, `auto_reload`=1, drop `enable` for 2 cycles mid-count -> `expired` pulses every 3 enabled cycles; the paused cycles hold `count`.
- N=0 auto-reload: `expired` high every enabled cycle. `irq_ack` never asserted -> `missed`=1 after the 2nd expiry. Then `irq_ack` coincident with an expiry -> `irq`=1, `missed`=0.
- Load collision: `load` N=7 on the same edge as a pending expiry (`count`=0, `enable`=1) -> `count`=7, `expired`=0, `irq` unchanged.
- Width wrap: WIDTH=4, load 15, auto-reload -> sequence 15..0,15; `expired` every 16 edges; no underflow to 15 via subtraction.
